// File: rtl/nibble_serial_subtractor_if.sv
// Operand/result handshake bundle for nibble_serial_subtractor.
// master drives operands and consumes results; slave is the subtractor.
interface nibble_serial_subtractor_if #(
    parameter int unsigned WIDTH = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] d;
    logic             bout;
    logic             ovf;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, d, bout, ovf
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, d, bout, ovf
    );
endinterface

// File: rtl/nibble_serial_subtractor.sv
// Sequential carry-select subtractor: d = a - b - bin, one 4-bit slice per cycle, LSB first.
// Define SUB_OVERFLOW_EN to compute the signed overflow flag; otherwise ovf is tied to 0.
module nibble_serial_subtractor #(
    parameter int unsigned WIDTH = 16
) (
    input logic                       clk,
    input logic                       rst_n,
    nibble_serial_subtractor_if.slave bus
);
    localparam int unsigned N  = WIDTH / 4;
    localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] KLast = KW'(N - 1);

    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_width_check
        $error("nibble_serial_subtractor: WIDTH must be a multiple of 4 and >= 4");
    end

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             br_q, br_d;
    logic             bout_q, bout_d;

    logic [KW+1:0] base;
    logic [3:0]    a_k, b_k, sel;
    logic [4:0]    r0, r1;
    logic          brw;

    // Both borrow-in cases are formed in parallel; the registered borrow picks one.
    always_comb begin
        base = {k_q, 2'b00};
        a_k  = a_q[base +: 4];
        b_k  = b_q[base +: 4];
        r0   = {1'b0, a_k} + {1'b0, ~b_k} + 5'd1;
        r1   = {1'b0, a_k} + {1'b0, ~b_k};
        sel  = br_q ? r1[3:0] : r0[3:0];
        brw  = ~(br_q ? r1[4] : r0[4]);
    end

`ifdef SUB_OVERFLOW_EN
    logic ovf_q, ovf_d;
`endif

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        a_d     = a_q;
        b_d     = b_q;
        d_d     = d_q;
        br_d    = br_q;
        bout_d  = bout_q;
`ifdef SUB_OVERFLOW_EN
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    br_d    = bus.bin;
                    k_d     = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                d_d[base +: 4] = sel;
                br_d           = brw;
                if (k_q == KLast) begin
                    bout_d  = brw;
`ifdef SUB_OVERFLOW_EN
                    ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) & (sel[3] != a_q[WIDTH-1]);
`endif
                    state_d = StDone;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            d_q     <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            a_q     <= a_d;
            b_q     <= b_d;
            d_q     <= d_d;
            br_q    <= br_d;
            bout_q  <= bout_d;
        end
    end

`ifdef SUB_OVERFLOW_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end
    assign bus.ovf = ovf_q;
`else
    assign bus.ovf = 1'b0;
`endif

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.d         = d_q;
    assign bus.bout      = bout_q;
endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Directed self-checking bench for nibble_serial_subtractor at WIDTH=16.
module tb_nibble_serial_subtractor;
`ifdef SUB_OVERFLOW_EN
    localparam logic OvfEn = 1'b1;
`else
    localparam logic OvfEn = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    nibble_serial_subtractor_if #(.WIDTH(16)) bus ();

    nibble_serial_subtractor #(
        .WIDTH(16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present operands for one edge, then scramble the inputs to prove they were latched.
    task automatic start(input logic [15:0] a, input logic [15:0] b, input logic bin);
        check("in_ready before accept", 32'(bus.in_ready), 32'd1);
        bus.a        = a;
        bus.b        = b;
        bus.bin      = bin;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.a        = ~a;
        bus.b        = ~b;
        bus.bin      = ~bin;
        check("in_ready after accept", 32'(bus.in_ready), 32'd0);
    endtask

    task automatic wait_result(input string tag, input logic [15:0] ed, input logic eb,
                               input logic eo);
        int cnt = 0;
        do begin
            @(posedge clk);
            #1;
            cnt++;
        end while (!bus.out_valid && cnt < 20);
        check({tag, " latency"}, 32'(cnt), 32'd4);
        check({tag, " d"}, 32'(bus.d), 32'(ed));
        check({tag, " bout"}, 32'(bus.bout), 32'(eb));
        check({tag, " ovf"}, 32'(bus.ovf), 32'(eo));
        check({tag, " in_ready in DONE"}, 32'(bus.in_ready), 32'd0);
    endtask

    task automatic drain(input string tag);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check({tag, " out_valid after drain"}, 32'(bus.out_valid), 32'd0);
        check({tag, " in_ready after drain"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.bin       = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        check("reset d", 32'(bus.d), 32'd0);
        check("reset bout", 32'(bus.bout), 32'd0);
        check("reset ovf", 32'(bus.ovf), 32'd0);
        check("reset out_valid", 32'(bus.out_valid), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("in_ready after reset", 32'(bus.in_ready), 32'd1);

        start(16'h1234, 16'h0034, 1'b0);
        wait_result("1234-0034", 16'h1200, 1'b0, 1'b0);
        drain("1234-0034");

        start(16'h0000, 16'h0001, 1'b0);
        wait_result("0000-0001", 16'hFFFF, 1'b1, 1'b0);
        drain("0000-0001");

        start(16'h1000, 16'h0FFF, 1'b1);
        wait_result("1000-0FFF-1", 16'h0000, 1'b0, 1'b0);
        drain("1000-0FFF-1");

        start(16'h0000, 16'h0000, 1'b1);
        wait_result("0000-0000-1", 16'hFFFF, 1'b1, 1'b0);
        drain("0000-0000-1");

        // Backpressure with a competing in_valid pulse held throughout.
        start(16'h5555, 16'h1111, 1'b0);
        wait_result("5555-1111", 16'h4444, 1'b0, 1'b0);
        bus.a        = 16'hFFFF;
        bus.b        = 16'h0000;
        bus.bin      = 1'b0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("bp out_valid", 32'(bus.out_valid), 32'd1);
            check("bp d", 32'(bus.d), 32'h4444);
            check("bp bout", 32'(bus.bout), 32'd0);
            check("bp in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check("bp idle out_valid", 32'(bus.out_valid), 32'd0);
        check("bp idle in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("bp accept after idle", 32'(bus.in_ready), 32'd0);
        wait_result("FFFF-0000", 16'hFFFF, 1'b0, 1'b0);
        drain("FFFF-0000");

        // Abort during slice 2.
        start(16'hABCD, 16'h1234, 1'b0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        check("abort d", 32'(bus.d), 32'd0);
        check("abort bout", 32'(bus.bout), 32'd0);
        check("abort ovf", 32'(bus.ovf), 32'd0);
        check("abort out_valid", 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("abort in_ready", 32'(bus.in_ready), 32'd1);
        check("abort no pulse", 32'(bus.out_valid), 32'd0);
        start(16'h00FF, 16'h000F, 1'b0);
        wait_result("00FF-000F", 16'h00F0, 1'b0, 1'b0);
        drain("00FF-000F");

        start(16'h8000, 16'h0001, 1'b0);
        wait_result("8000-0001", 16'h7FFF, 1'b0, OvfEn);
        drain("8000-0001");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
